// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: request op codes, ALU control
// encodings and the sequencer FSM states.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_MUL = 3'b100
  } op_t;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Initiator for an external combinational 8-bit ALU: runs single-cycle ops directly and
// builds MUL (low byte) as a fixed-length shift-add loop on the ALU's ADD.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MUL_STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic [WIDTH-1:0] alu_srca_o,
  output logic [WIDTH-1:0] alu_srcb_o,
  output logic [1:0]       alu_control_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o
);

  localparam int unsigned CntW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_STEPS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplr_d       = mplr_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          a_d    = req_a_i;
          b_d    = req_b_i;
          ctrl_d = req_op_i[1:0];
          case (req_op_i)
            OP_AND, OP_OR, OP_ADD, OP_SUB: state_d = ST_EXEC;
            OP_MUL: begin
              acc_d   = '0;
              mcand_d = req_a_i;
              mplr_d  = req_b_i;
              cnt_d   = '0;
              state_d = ST_MUL;
            end
            default: begin
              // Illegal op never touches the ALU; respond straight away.
              rsp_result_d = '0;
              rsp_zero_d   = 1'b1;
              rsp_err_d    = 1'b1;
              state_d      = ST_RESP;
            end
          endcase
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result_i;
        rsp_zero_d   = alu_zero_i;
        rsp_err_d    = 1'b0;
        state_d      = ST_RESP;
      end
      ST_MUL: begin
        acc_d   = alu_result_i;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          rsp_result_d = alu_result_i;
          rsp_zero_d   = alu_zero_i;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= ALU_AND;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplr_q       <= '0;
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplr_q       <= mplr_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // ALU inputs are forced to zero outside the computing states.
  always_comb begin
    alu_srca_o    = '0;
    alu_srcb_o    = '0;
    alu_control_o = ALU_AND;
    case (state_q)
      ST_EXEC: begin
        alu_srca_o    = a_q;
        alu_srcb_o    = b_q;
        alu_control_o = ctrl_q;
      end
      ST_MUL: begin
        alu_srca_o    = acc_q;
        alu_srcb_o    = mplr_q[0] ? mcand_q : '0;
        alu_control_o = ALU_ADD;
      end
      default: ;
    endcase
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU, a directed vector table,
// randomized ops against an arithmetic model, backpressure and async-reset sequences.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'b000;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic [7:0] alu_srca, alu_srcb, alu_result;
  logic [1:0] alu_control;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .MUL_STEPS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .alu_srca_o   (alu_srca),
    .alu_srcb_o   (alu_srcb),
    .alu_control_o(alu_control),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .rsp_err_o    (rsp_err)
  );

  // Stand-in for the external combinational ALU.
  always_comb begin
    case (alu_control)
      2'b00:   alu_result = alu_srca & alu_srcb;
      2'b01:   alu_result = alu_srca | alu_srcb;
      2'b10:   alu_result = alu_srca + alu_srcb;
      default: alu_result = alu_srca - alu_srcb;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the op code, latency in cycles after the accept edge.
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic zero, output logic err,
                       output int lat);
    int prod;
    err = 1'b0;
    lat = 1;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = 8'((int'(a) + int'(b)) % 256);
      3'd3: res = 8'((int'(a) - int'(b) + 256) % 256);
      3'd4: begin
        prod = int'(a) * int'(b);
        res  = 8'(prod % 256);
        lat  = 8;
      end
      default: begin
        res = 8'h00;
        err = 1'b1;
        lat = 0;
      end
    endcase
    zero = err ? 1'b1 : (res == 8'h00);
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res, input logic exp_zero,
                        input logic exp_err, input int exp_lat, input int stall);
    int guard = 0;
    int lat = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({nm, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " result"}, 32'(rsp_result), 32'(exp_res));
    check({nm, " zero"}, 32'(rsp_zero), 32'(exp_zero));
    check({nm, " err"}, 32'(rsp_err), 32'(exp_err));
    check({nm, " alu idle"}, {22'd0, alu_control, alu_srca, alu_srcb}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, " stall held"}, {20'd0, rsp_valid, req_ready, rsp_err, rsp_zero, rsp_result},
            {20'd0, 1'b1, 1'b0, exp_err, exp_zero, exp_res});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, " back to idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  typedef struct {
    string      nm;
    logic [2:0] op;
    logic [7:0] a, b, res;
    logic       zero, err;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0] op;
    logic [7:0] a, b, res;
    logic       zero, err;
    int         lat;

    vecs.push_back('{"add7f", 3'd2, 8'h7f, 8'h01, 8'h80, 1'b0, 1'b0, 1});
    vecs.push_back('{"sub_eq", 3'd3, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1});
    vecs.push_back('{"sub_wrap", 3'd3, 8'h00, 8'h01, 8'hff, 1'b0, 1'b0, 1});
    vecs.push_back('{"and", 3'd0, 8'hf0, 8'h0f, 8'h00, 1'b1, 1'b0, 1});
    vecs.push_back('{"or", 3'd1, 8'hf0, 8'h0f, 8'hff, 1'b0, 1'b0, 1});
    vecs.push_back('{"mul_0d0b", 3'd4, 8'h0d, 8'h0b, 8'h8f, 1'b0, 1'b0, 8});
    vecs.push_back('{"mul_ovf", 3'd4, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 8});
    vecs.push_back('{"mul_by0", 3'd4, 8'hff, 8'h00, 8'h00, 1'b1, 1'b0, 8});
    vecs.push_back('{"illegal7", 3'd7, 8'haa, 8'h55, 8'h00, 1'b1, 1'b1, 0});
    vecs.push_back('{"illegal5", 3'd5, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 0});

    #1;
    check("reset outs", {10'd0, rsp_valid, rsp_zero, rsp_err, alu_control, rsp_result,
          alu_srca}, 32'd0);
    check("reset srcb/ready", {23'd0, req_ready, alu_srcb}, 32'h100);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero,
             vecs[i].err, vecs[i].lat, 0);

    // Backpressure with a request pulse that must be ignored.
    req_valid = 1'b1;
    req_op = 3'd2;
    req_a = 8'h01;
    req_b = 8'h02;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 8'hff;
        req_b = 8'hff;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      check("bp stall", {22'd0, rsp_valid, req_ready, rsp_result}, {22'd0, 2'b10, 8'h03});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp release", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("bp pulse dropped", {30'd0, rsp_valid, req_ready}, 32'd1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      model(op, a, b, res, zero, err, lat);
      run_op($sformatf("rand%0d op%0d %0h,%0h", i, op, a, b), op, a, b, res, zero, err, lat,
             int'($urandom_range(0, 2)));
    end

    // Async reset in the middle of a MUL.
    run_op("pre-reset or", 3'd1, 8'hf0, 8'h0f, 8'hff, 1'b0, 1'b0, 1, 0);
    req_valid = 1'b1;
    req_op = 3'd4;
    req_a = 8'h0d;
    req_b = 8'h0b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mul in flight", {29'd0, req_ready, alu_control}, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async reset outs", {10'd0, rsp_valid, rsp_zero, rsp_err, alu_control, rsp_result,
          alu_srca}, 32'd0);
    check("async reset srcb", {23'd0, req_ready, alu_srcb}, 32'h100);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("ready after reset", 32'(req_ready), 32'd1);
    run_op("post-reset add", 3'd2, 8'h05, 8'h06, 8'h0b, 1'b0, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Initiator side of the 8-bit ALU datapath interface. It accepts operation requests over a valid/ready handshake and drives SrcA, SrcB and ALUControl onto an external combinational alu. It captures ALUResult and Zero, and returns them over a valid/ready response channel. It also builds an 8-bit multiply (low byte) as a multicycle shift-add sequence that reuses the ALU's ADD.

Parameters:
WIDTH, 8, datapath width; must match the attached alu (fixed 8 in this design)
MUL_STEPS, WIDTH, shift-add iterations per MUL

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 MUL, others illegal
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
alu_srca  output  WIDTH  to alu SrcA
alu_srcb  output  WIDTH  to alu SrcB
alu_control  output  2  to alu ALUControl (00 AND, 01 OR, 10 ADD, 11 SUB)
alu_result  input  WIDTH  from alu ALUResult
alu_zero  input  1  from alu Zero
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  result
rsp_zero  output  1  result == 0
rsp_err  output  1  illegal op code

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (immediate, async):
  - state IDLE; all operand, accumulator and counter registers 0.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - alu_srca=0, alu_srcb=0, alu_control=00.
- States: IDLE, EXEC, MUL, RESP.
- req_ready=1 only in IDLE. A request transfers at a rising edge with req_valid && req_ready; call this edge E0.
- IDLE on transfer:
  - Register a, b and op.
  - op 000–011 → EXEC.
  - op 100 → MUL with acc=0, mcand=a, mplr=b, cnt=0.
  - Illegal op → RESP with rsp_result=0, rsp_zero=1, rsp_err=1.
- EXEC (one cycle):
  - alu_srca=a_reg, alu_srcb=b_reg, alu_control=op[1:0].
  - At E1 capture rsp_result=alu_result, rsp_zero=alu_zero, rsp_err=0 → RESP.
- MUL (MUL_STEPS cycles):
  - alu_control=10, alu_srca=acc, alu_srcb = mplr[0] ? mcand : 0.
  - Each edge: acc<=alu_result, mcand<=mcand<<1, mplr<=mplr>>1, cnt++.
  - At the edge where cnt==MUL_STEPS-1, capture rsp_result=alu_result, rsp_zero=alu_zero → RESP. This is E8 for WIDTH=8.
  - Fixed iteration count, no early exit. Overflow beyond WIDTH bits is discarded.
- RESP:
  - rsp_valid=1; rsp_result, rsp_zero and rsp_err are held stable until rsp_valid && rsp_ready at an edge, then → IDLE.
  - No bypass: the next request is accepted at the earliest one cycle after the response handshake.
- Response timing:
  - Single-cycle ops: rsp_valid first high in the cycle after E1.
  - MUL: rsp_valid first high after E8.
  - Illegal op: rsp_valid first high after E0.
- Outside EXEC and MUL, alu_srca=0, alu_srcb=0, alu_control=00, so the ALU sees deterministic operands.
- Arithmetic: all modulo 2^WIDTH. SUB wraps (00−01=FF). rsp_zero is always the ALU Zero of the final computing cycle, or 1 for illegal op.
- Input sampling: req_* are ignored while req_ready=0. rsp_ready is ignored while rsp_valid=0.
- Reset mid-operation: in-flight op and pending response are discarded; req_ready=1 in the first cycle after reset deasserts.

Decomposition:
- Package alu_seq_pkg holds:
  - op_t enum: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL.
  - ALUControl constants: ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10, ALU_SUB=2'b11.
  - state_t enum.
- No internal sub-module. The existing alu is instantiated alongside the sequencer at the next level up and in the bench, not inside this block.

Test Plan:
- ADD a=7F b=01, rsp_ready=1 → rsp_valid first high after E1; rsp_result=80, rsp_zero=0, rsp_err=0; req_ready back to 1 the cycle after the response handshake.
- SUB a=33 b=33 → result 00, zero 1. Then SUB a=00 b=01 → result FF, zero 0. Then AND F0,0F → 00, zero 1. Then OR F0,0F → FF.
- MUL a=0D b=0B → rsp_valid first high after E8, result 8F, zero 0. MUL a=10 b=10 → result 00, zero 1. MUL a=FF b=00 → 00.
- Backpressure: ADD 01+02 with rsp_ready=0 for 5 cycles → rsp_result=03 stable, rsp_valid=1, req_ready=0; a req_valid pulse during the stall is not accepted. rsp_ready=1 → IDLE next cycle.
- Illegal op 111, a=AA b=55 → rsp_valid first high after E0; rsp_result=00, rsp_zero=1, rsp_err=1; no ALU activity (alu_control=00, srcs 0).
- Reset asserted asynchronously during MUL step 4 → rsp_valid=0, all outputs at reset values without waiting for clk. After deassert, ADD 05+06 → 0B correct.
